// File: rtl/prt_pkg.sv
// Shared types and width helpers for the packet reference table.
//   slot_state_e : per-slot ownership state
//   wr_state_e   : write-side FSM states
//   rd_state_e   : read-side FSM states
//   calc_*_w     : derived widths from NUM_SLOTS / MEM_DEPTH
package prt_pkg;

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        WRITING = 2'd1,
        VALID   = 2'd2
    } slot_state_e;

    typedef enum logic {
        W_IDLE   = 1'b0,
        W_ACTIVE = 1'b1
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_VALID = 2'd2
    } rd_state_e;

    // max(1, clog2(n))
    function automatic int calc_slot_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Offset width inside one slot; at least one bit so the slice stays legal.
    function automatic int calc_addr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    // Wide enough to hold the value MEM_DEPTH itself.
    function automatic int calc_len_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/prt_frame_mem.sv
// Simple dual-port frame RAM: one write port, one read port, 1-cycle
// synchronous read. Contents are not reset.
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address, sampled every clock
//   rdata : registered read data
module prt_frame_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8192,
    parameter int AW         = 13
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/prt_nslot.sv
// Packet reference table with NUM_SLOTS frame slots of up to MEM_DEPTH bytes.
// One writer and one reader may run concurrently on different slots.
//
// Ports (method style: EN_x strobes, RDY_x ready):
//   CLK, RST_N                     : clock, async active-low reset
//   *_start_writing_prt_entry      : allocate lowest FREE slot, begin write
//   *_write_prt_entry              : stream one byte into the write slot
//   *_finish_writing_prt_entry     : commit frame, length = bytes written
//   *_invalidate_prt_entry         : return a VALID slot to FREE
//   *_start_reading_prt_entry      : begin streaming a VALID slot
//   *_read_prt_entry               : {last, byte}; EN consumes current byte
//   read_prt_entry_len             : committed length of active read slot
//   is_prt_slot_free, free_slot_count : registered-state slot occupancy
//
// Write FSM
//   state    | meaning
//   W_IDLE   | no frame being written
//   W_ACTIVE | bytes streaming into wr_slot
// Read FSM
//   state    | meaning
//   R_IDLE   | no frame being read
//   R_FETCH  | RAM latency cycle for the first byte
//   R_VALID  | read_prt_entry holds a valid byte
module prt_nslot
    import prt_pkg::*;
#(
    parameter int  DATA_WIDTH        = 8,
    parameter int  MEM_DEPTH         = 1518,
    parameter int  NUM_SLOTS         = 4,
    parameter int  AUTO_FREE_ON_READ = 0,
    localparam int SLOT_W            = calc_slot_w(NUM_SLOTS),
    localparam int ADDR_W            = calc_addr_w(MEM_DEPTH),
    localparam int LEN_W             = calc_len_w(MEM_DEPTH)
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  EN_start_writing_prt_entry,
    output logic [SLOT_W-1:0]     start_writing_prt_entry,
    output logic                  RDY_start_writing_prt_entry,
    input  logic [DATA_WIDTH-1:0] write_prt_entry_data,
    input  logic                  EN_write_prt_entry,
    output logic                  RDY_write_prt_entry,
    input  logic                  EN_finish_writing_prt_entry,
    output logic                  RDY_finish_writing_prt_entry,
    input  logic [SLOT_W-1:0]     invalidate_prt_entry_slot,
    input  logic                  EN_invalidate_prt_entry,
    output logic                  RDY_invalidate_prt_entry,
    input  logic [SLOT_W-1:0]     start_reading_prt_entry_slot,
    input  logic                  EN_start_reading_prt_entry,
    output logic                  RDY_start_reading_prt_entry,
    input  logic                  EN_read_prt_entry,
    output logic [DATA_WIDTH:0]   read_prt_entry,
    output logic                  RDY_read_prt_entry,
    output logic [LEN_W-1:0]      read_prt_entry_len,
    output logic                  is_prt_slot_free,
    output logic                  RDY_is_prt_slot_free,
    output logic [SLOT_W:0]       free_slot_count
);

    localparam int MEM_AW    = SLOT_W + ADDR_W;
    localparam int MEM_WORDS = NUM_SLOTS * (1 << ADDR_W);

    slot_state_e           slot_st  [NUM_SLOTS];
    logic [LEN_W-1:0]      slot_len [NUM_SLOTS];

    wr_state_e             wr_st, wr_st_nx;
    logic [SLOT_W-1:0]     wr_slot;
    logic [LEN_W-1:0]      wr_ptr;

    rd_state_e             rd_st, rd_st_nx;
    logic [SLOT_W-1:0]     rd_slot;
    logic [ADDR_W-1:0]     rd_ptr;
    logic [LEN_W-1:0]      rd_len;
    logic                  rd_last;
    logic [MEM_AW-1:0]     mem_raddr;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic                  any_free;
    logic [SLOT_W-1:0]     alloc_slot;
    logic [SLOT_W:0]       free_cnt;

    logic inv_idx_ok, sr_idx_ok;
    logic fire_sw, fire_w, fire_fin, fire_inv, fire_sr, fire_rd, auto_free;

    // Descending scan so the last hit is the lowest-index FREE slot.
    always_comb begin
        any_free   = 1'b0;
        alloc_slot = '0;
        free_cnt   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (slot_st[i] == FREE) begin
                any_free   = 1'b1;
                alloc_slot = SLOT_W'(i);
                free_cnt   = free_cnt + (SLOT_W + 1)'(1);
            end
        end
    end

    assign inv_idx_ok = int'(invalidate_prt_entry_slot) < NUM_SLOTS;
    assign sr_idx_ok  = int'(start_reading_prt_entry_slot) < NUM_SLOTS;

    assign rd_last = (LEN_W'(rd_ptr) == (rd_len - LEN_W'(1)));

    assign RDY_start_writing_prt_entry  = (wr_st == W_IDLE) && any_free;
    assign RDY_write_prt_entry          = (wr_st == W_ACTIVE) && (wr_ptr < LEN_W'(MEM_DEPTH));
    assign RDY_finish_writing_prt_entry = (wr_st == W_ACTIVE) && (wr_ptr != '0);
    // The slot being streamed out must not be pulled from under the reader.
    assign RDY_invalidate_prt_entry     = inv_idx_ok
                                        && (slot_st[invalidate_prt_entry_slot] == VALID)
                                        && !((rd_st != R_IDLE) && (rd_slot == invalidate_prt_entry_slot));
    assign RDY_start_reading_prt_entry  = (rd_st == R_IDLE) && sr_idx_ok
                                        && (slot_st[start_reading_prt_entry_slot] == VALID);
    assign RDY_read_prt_entry           = (rd_st == R_VALID);

    assign fire_sw   = EN_start_writing_prt_entry && RDY_start_writing_prt_entry;
    assign fire_fin  = EN_finish_writing_prt_entry && RDY_finish_writing_prt_entry;
    // A commit closes the frame; a byte presented alongside it is not appended.
    assign fire_w    = EN_write_prt_entry && RDY_write_prt_entry && !fire_fin;
    assign fire_inv  = EN_invalidate_prt_entry && RDY_invalidate_prt_entry;
    assign fire_sr   = EN_start_reading_prt_entry && RDY_start_reading_prt_entry;
    assign fire_rd   = EN_read_prt_entry && RDY_read_prt_entry;
    assign auto_free = (AUTO_FREE_ON_READ != 0) && fire_rd && rd_last;

    assign start_writing_prt_entry = alloc_slot;
    assign read_prt_entry          = RDY_read_prt_entry ? {rd_last, mem_rdata} : '0;
    assign read_prt_entry_len      = rd_len;
    assign is_prt_slot_free        = any_free;
    assign RDY_is_prt_slot_free    = 1'b1;
    assign free_slot_count         = free_cnt;

    always_comb begin
        wr_st_nx = wr_st;
        case (wr_st)
            W_IDLE:   if (fire_sw)  wr_st_nx = W_ACTIVE;
            W_ACTIVE: if (fire_fin) wr_st_nx = W_IDLE;
            default:  wr_st_nx = W_IDLE;
        endcase
    end

    // Read address runs one ahead on a consume so bytes stream without bubbles.
    always_comb begin
        rd_st_nx  = rd_st;
        mem_raddr = {rd_slot, rd_ptr};
        case (rd_st)
            R_IDLE: begin
                if (fire_sr) begin
                    rd_st_nx  = R_FETCH;
                    mem_raddr = {start_reading_prt_entry_slot, ADDR_W'(0)};
                end
            end
            R_FETCH: rd_st_nx = R_VALID;
            R_VALID: begin
                if (fire_rd) begin
                    if (rd_last) begin
                        rd_st_nx = R_IDLE;
                    end else begin
                        mem_raddr = {rd_slot, rd_ptr + ADDR_W'(1)};
                    end
                end
            end
            default: rd_st_nx = R_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_st   <= W_IDLE;
            wr_slot <= '0;
            wr_ptr  <= '0;
        end else begin
            wr_st <= wr_st_nx;
            if (fire_sw) begin
                wr_slot <= alloc_slot;
                wr_ptr  <= '0;
            end else if (fire_w) begin
                wr_ptr <= wr_ptr + LEN_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_st   <= R_IDLE;
            rd_slot <= '0;
            rd_ptr  <= '0;
            rd_len  <= '0;
        end else begin
            rd_st <= rd_st_nx;
            if (fire_sr) begin
                rd_slot <= start_reading_prt_entry_slot;
                rd_ptr  <= '0;
                rd_len  <= slot_len[start_reading_prt_entry_slot];
            end else if (fire_rd && !rd_last) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
        end
    end

    // The RDY qualifiers guarantee the four slot events never hit the same slot.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_st[i]  <= FREE;
                slot_len[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (fire_sw && (alloc_slot == SLOT_W'(i))) begin
                    slot_st[i] <= WRITING;
                end
                if (fire_fin && (wr_slot == SLOT_W'(i))) begin
                    slot_st[i]  <= VALID;
                    slot_len[i] <= wr_ptr;
                end
                if (fire_inv && (invalidate_prt_entry_slot == SLOT_W'(i))) begin
                    slot_st[i] <= FREE;
                end
                if (auto_free && (rd_slot == SLOT_W'(i))) begin
                    slot_st[i] <= FREE;
                end
            end
        end
    end

    prt_frame_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MEM_WORDS),
        .AW         (MEM_AW)
    ) u_mem (
        .clk   (CLK),
        .we    (fire_w),
        .waddr ({wr_slot, wr_ptr[ADDR_W-1:0]}),
        .wdata (write_prt_entry_data),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_prt_nslot.sv
module tb_prt_nslot;

    localparam int NS = 4;
    localparam int MD = 1518;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       RST_N;
    logic       sel;
    logic       en_sw, en_w, en_fin, en_inv, en_sr, en_rd;
    logic [7:0] wdata;
    logic [1:0] inv_slot, sr_slot;

    logic [1:0]  d0_sw_slot, d1_sw_slot;
    logic        d0_rdy_sw, d1_rdy_sw, d0_rdy_w, d1_rdy_w, d0_rdy_fin, d1_rdy_fin;
    logic        d0_rdy_inv, d1_rdy_inv, d0_rdy_sr, d1_rdy_sr, d0_rdy_rd, d1_rdy_rd;
    logic [8:0]  d0_rd_data, d1_rd_data;
    logic [10:0] d0_rd_len, d1_rd_len;
    logic        d0_is_free, d1_is_free, d0_rdy_isf, d1_rdy_isf;
    logic [2:0]  d0_cnt, d1_cnt;

    // Observed view of whichever instance is selected.
    logic [1:0]  sw_slot;
    logic        rdy_sw, rdy_w, rdy_fin, rdy_inv, rdy_sr, rdy_rd, is_free, rdy_isf;
    logic [8:0]  rd_data;
    logic [10:0] rd_len;
    logic [2:0]  free_cnt;

    assign sw_slot  = sel ? d1_sw_slot : d0_sw_slot;
    assign rdy_sw   = sel ? d1_rdy_sw  : d0_rdy_sw;
    assign rdy_w    = sel ? d1_rdy_w   : d0_rdy_w;
    assign rdy_fin  = sel ? d1_rdy_fin : d0_rdy_fin;
    assign rdy_inv  = sel ? d1_rdy_inv : d0_rdy_inv;
    assign rdy_sr   = sel ? d1_rdy_sr  : d0_rdy_sr;
    assign rdy_rd   = sel ? d1_rdy_rd  : d0_rdy_rd;
    assign rd_data  = sel ? d1_rd_data : d0_rd_data;
    assign rd_len   = sel ? d1_rd_len  : d0_rd_len;
    assign is_free  = sel ? d1_is_free : d0_is_free;
    assign rdy_isf  = sel ? d1_rdy_isf : d0_rdy_isf;
    assign free_cnt = sel ? d1_cnt     : d0_cnt;

    prt_nslot #(.DATA_WIDTH(8), .MEM_DEPTH(MD), .NUM_SLOTS(NS), .AUTO_FREE_ON_READ(0)) dut0 (
        .CLK(CLK), .RST_N(RST_N),
        .EN_start_writing_prt_entry(en_sw && !sel), .start_writing_prt_entry(d0_sw_slot),
        .RDY_start_writing_prt_entry(d0_rdy_sw),
        .write_prt_entry_data(wdata), .EN_write_prt_entry(en_w && !sel), .RDY_write_prt_entry(d0_rdy_w),
        .EN_finish_writing_prt_entry(en_fin && !sel), .RDY_finish_writing_prt_entry(d0_rdy_fin),
        .invalidate_prt_entry_slot(inv_slot), .EN_invalidate_prt_entry(en_inv && !sel),
        .RDY_invalidate_prt_entry(d0_rdy_inv),
        .start_reading_prt_entry_slot(sr_slot), .EN_start_reading_prt_entry(en_sr && !sel),
        .RDY_start_reading_prt_entry(d0_rdy_sr),
        .EN_read_prt_entry(en_rd && !sel), .read_prt_entry(d0_rd_data), .RDY_read_prt_entry(d0_rdy_rd),
        .read_prt_entry_len(d0_rd_len), .is_prt_slot_free(d0_is_free),
        .RDY_is_prt_slot_free(d0_rdy_isf), .free_slot_count(d0_cnt)
    );

    prt_nslot #(.DATA_WIDTH(8), .MEM_DEPTH(MD), .NUM_SLOTS(NS), .AUTO_FREE_ON_READ(1)) dut1 (
        .CLK(CLK), .RST_N(RST_N),
        .EN_start_writing_prt_entry(en_sw && sel), .start_writing_prt_entry(d1_sw_slot),
        .RDY_start_writing_prt_entry(d1_rdy_sw),
        .write_prt_entry_data(wdata), .EN_write_prt_entry(en_w && sel), .RDY_write_prt_entry(d1_rdy_w),
        .EN_finish_writing_prt_entry(en_fin && sel), .RDY_finish_writing_prt_entry(d1_rdy_fin),
        .invalidate_prt_entry_slot(inv_slot), .EN_invalidate_prt_entry(en_inv && sel),
        .RDY_invalidate_prt_entry(d1_rdy_inv),
        .start_reading_prt_entry_slot(sr_slot), .EN_start_reading_prt_entry(en_sr && sel),
        .RDY_start_reading_prt_entry(d1_rdy_sr),
        .EN_read_prt_entry(en_rd && sel), .read_prt_entry(d1_rd_data), .RDY_read_prt_entry(d1_rdy_rd),
        .read_prt_entry_len(d1_rd_len), .is_prt_slot_free(d1_is_free),
        .RDY_is_prt_slot_free(d1_rdy_isf), .free_slot_count(d1_cnt)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_mem [NS][MD];
    int         exp_len [NS];
    logic [8:0] sbq [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_frame(input int slot);
        for (int i = 0; i < exp_len[slot]; i++) begin
            sbq.push_back({(i == exp_len[slot] - 1), exp_mem[slot][i]});
        end
    endtask

    task automatic rd_step();
        logic [8:0] e;
        if (rdy_rd && sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("rd_byte", {23'd0, rd_data}, {23'd0, e});
            en_rd = 1'b1;
        end else begin
            en_rd = 1'b0;
        end
    endtask

    task automatic drain(input int bound);
        int g = 0;
        while (sbq.size() > 0 && g < bound) begin
            rd_step();
            cyc();
            g++;
        end
        en_rd = 1'b0;
        chk("rd_drain_left", sbq.size(), 0);
        sbq.delete();
    endtask

    task automatic write_frame(input int n, input int base, output int slot);
        int g = 0;
        while (!rdy_sw && g < 100) begin
            cyc();
            g++;
        end
        chk("sw_rdy", {31'd0, rdy_sw}, 1);
        slot  = int'(sw_slot);
        en_sw = 1'b1;
        cyc();
        en_sw = 1'b0;
        #1;
        chk("w_rdy_start", {31'd0, rdy_w}, 1);
        chk("fin_rdy_empty", {31'd0, rdy_fin}, 0);
        for (int i = 0; i < n; i++) begin
            wdata = 8'(base + i);
            exp_mem[slot][i] = wdata;
            en_w = 1'b1;
            chk("w_rdy", {31'd0, rdy_w}, 1);
            cyc();
        end
        en_w = 1'b0;
        #1;
        if (n == MD) chk("w_rdy_full", {31'd0, rdy_w}, 0);
        chk("fin_rdy", {31'd0, rdy_fin}, 1);
        en_fin = 1'b1;
        cyc();
        en_fin = 1'b0;
        exp_len[slot] = n;
    endtask

    task automatic read_frame(input int slot);
        sr_slot = 2'(slot);
        #1;
        chk("sr_rdy", {31'd0, rdy_sr}, 1);
        en_sr = 1'b1;
        push_frame(slot);
        cyc();
        en_sr = 1'b0;
        chk("rd_fetch_rdy", {31'd0, rdy_rd}, 0);
        chk("rd_fetch_data", {23'd0, rd_data}, 0);
        chk("rd_len", {21'd0, rd_len}, exp_len[slot]);
        cyc();
        chk("rd_first_rdy", {31'd0, rdy_rd}, 1);
        drain(4000);
    endtask

    initial begin
        int s;
        int k;
        int g;
        RST_N = 1'b0; sel = 1'b0;
        en_sw = 0; en_w = 0; en_fin = 0; en_inv = 0; en_sr = 0; en_rd = 0;
        wdata = '0; inv_slot = '0; sr_slot = '0;
        repeat (3) cyc();
        RST_N = 1'b1;
        cyc();

        chk("rst_cnt", {29'd0, free_cnt}, 4);
        chk("rst_is_free", {31'd0, is_free}, 1);
        chk("rst_rdy_isf", {31'd0, rdy_isf}, 1);
        chk("rst_rdy_sw", {31'd0, rdy_sw}, 1);
        chk("rst_sw_slot", {30'd0, sw_slot}, 0);
        chk("rst_rdy_w", {31'd0, rdy_w}, 0);
        chk("rst_rdy_fin", {31'd0, rdy_fin}, 0);
        chk("rst_rdy_inv", {31'd0, rdy_inv}, 0);
        chk("rst_rdy_sr", {31'd0, rdy_sr}, 0);
        chk("rst_rdy_rd", {31'd0, rdy_rd}, 0);
        chk("rst_rd_data", {23'd0, rd_data}, 0);
        chk("rst_rd_len", {21'd0, rd_len}, 0);

        // Short frame round trip.
        write_frame(10, 0, s);
        chk("alloc0", s, 0);
        read_frame(0);

        // Fill the table.
        write_frame(20, 8'h40, s); chk("alloc1", s, 1);
        write_frame(30, 8'h80, s); chk("alloc2", s, 2);
        write_frame(40, 8'hC0, s); chk("alloc3", s, 3);
        #1;
        chk("full_rdy_sw", {31'd0, rdy_sw}, 0);
        chk("full_cnt", {29'd0, free_cnt}, 0);
        chk("full_is_free", {31'd0, is_free}, 0);

        // Free slot 2, reuse it for a maximum-length frame.
        inv_slot = 2'd2;
        #1;
        chk("inv2_rdy", {31'd0, rdy_inv}, 1);
        en_inv = 1'b1;
        cyc();
        en_inv = 1'b0;
        chk("inv2_cnt", {29'd0, free_cnt}, 1);
        chk("inv2_rdy_after", {31'd0, rdy_inv}, 0);
        chk("inv2_alloc", {30'd0, sw_slot}, 2);
        write_frame(MD, 5, s);
        chk("alloc_max", s, 2);
        read_frame(2);

        // Free slot 3, then invalidate 0 + allocate + start read of 1 together.
        inv_slot = 2'd3;
        #1;
        en_inv = 1'b1;
        cyc();
        en_inv = 1'b0;
        chk("inv3_cnt", {29'd0, free_cnt}, 1);
        inv_slot = 2'd0;
        sr_slot  = 2'd1;
        en_inv = 1'b1; en_sw = 1'b1; en_sr = 1'b1;
        #1;
        chk("sim_alloc", {30'd0, sw_slot}, 3);
        chk("sim_rdy_sr", {31'd0, rdy_sr}, 1);
        push_frame(1);
        cyc();
        en_inv = 1'b0; en_sw = 1'b0; en_sr = 1'b0;
        chk("sim_cnt", {29'd0, free_cnt}, 1);
        inv_slot = 2'd1;
        k = 0; g = 0;
        while ((k < 25 || sbq.size() > 0) && g < 200) begin
            if (k < 25) begin
                wdata = 8'(8'h11 + 3 * k);
                exp_mem[3][k] = wdata;
                en_w = 1'b1;
                k++;
            end else begin
                en_w = 1'b0;
            end
            if (sbq.size() > 0) chk("inv_during_read", {31'd0, rdy_inv}, 0);
            rd_step();
            cyc();
            g++;
        end
        en_w = 1'b0; en_rd = 1'b0;
        chk("conc_drain_left", sbq.size(), 0);
        sbq.delete();
        #1;
        chk("inv_after_read", {31'd0, rdy_inv}, 1);
        sr_slot = 2'd3;
        en_fin = 1'b1;
        #1;
        chk("sr_during_fin", {31'd0, rdy_sr}, 0);
        cyc();
        en_fin = 1'b0;
        exp_len[3] = 25;
        read_frame(3);

        // Auto-free instance.
        sel = 1'b1;
        #1;
        chk("af_cnt0", {29'd0, free_cnt}, 4);
        write_frame(12, 8'h33, s);
        chk("af_alloc", s, 0);
        chk("af_cnt_valid", {29'd0, free_cnt}, 3);
        read_frame(0);
        chk("af_cnt_freed", {29'd0, free_cnt}, 4);
        sr_slot = 2'd0;
        #1;
        chk("af_rdy_sr", {31'd0, rdy_sr}, 0);

        // Reset in the middle of a read.
        write_frame(12, 8'h60, s);
        read_start_partial: begin
            sr_slot = 2'd0;
            en_sr = 1'b1;
            push_frame(0);
            cyc();
            en_sr = 1'b0;
            cyc();
            rd_step(); cyc();
            rd_step(); cyc();
            en_rd = 1'b0;
            chk("mid_rdy_rd", {31'd0, rdy_rd}, 1);
        end
        RST_N = 1'b0;
        #1;
        chk("rst_mid_rdy_rd", {31'd0, rdy_rd}, 0);
        chk("rst_mid_data", {23'd0, rd_data}, 0);
        chk("rst_mid_cnt", {29'd0, free_cnt}, 4);
        sbq.delete();
        cyc();
        RST_N = 1'b1;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
